// File: rtl/alu_wide_seq.sv
// Multi-word sequencer for the shared N-bit ALU: wide ADD, INC and XOR computed one word
// per cycle, least-significant word first, with the carry chained through ALU_ADC.
module alu_wide_seq #(
    parameter int          N       = 8,
    parameter int          WORDS   = 4,
    parameter logic [2:0]  ALU_ADD = 3'd0,
    parameter logic [2:0]  ALU_ADC = 3'd2,
    parameter logic [2:0]  ALU_INC = 3'd3,
    parameter logic [2:0]  ALU_XOR = 3'd6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WORDS*N-1:0]   a_i,
    input  logic [WORDS*N-1:0]   b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WORDS*N-1:0]   result_o,
    output logic                 carry_o,
    output logic                 zero_o,
    output logic                 err_o,
    output logic                 alu_enable_o,
    output logic [2:0]           alu_mode_o,
    output logic [N-1:0]         alu_a_o,
    output logic [N-1:0]         alu_b_o,
    input  logic [N-1:0]         alu_out_i,
    input  logic                 alu_flag_zero_i,
    input  logic                 alu_flag_carry_i
);
    localparam int             W    = WORDS * N;
    localparam int             IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);
    localparam logic [1:0]     OP_ADD = 2'd0;
    localparam logic [1:0]     OP_INC = 2'd1;
    localparam logic [1:0]     OP_XOR = 2'd2;
    localparam logic [1:0]     OP_ERR = 2'd3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wi_q, wi_d, ci_q, ci_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [1:0]      op_q, op_d;
    logic            zacc_q, zacc_d, carry_q, carry_d, zero_q, zero_d;
    logic            err_q, err_d, done_q, done_d;
    logic            alu_en_q, alu_en_d;
    logic [2:0]      alu_mode_q, alu_mode_d;
    logic [N-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic            iss_en_s, iss_first_s;
    logic [1:0]      iss_op_s;
    logic [N-1:0]    iss_a_s, iss_b_s;

    // Only the first word uses a carry-free mode so stale ALU carry never leaks in.
    function automatic logic [2:0] word_mode(input logic [1:0] op, input logic first);
        logic [2:0] m;
        case (op)
            OP_ADD:  m = first ? ALU_ADD : ALU_ADC;
            OP_INC:  m = first ? ALU_INC : ALU_ADC;
            OP_XOR:  m = ALU_XOR;
            default: m = 3'd0;
        endcase
        return m;
    endfunction

    // Next-state, word capture and the registered ALU drive for the following cycle.
    always_comb begin
        state_d     = state_q;
        wi_d        = wi_q;
        ci_d        = ci_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        zacc_d      = zacc_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
        done_d      = 1'b0;
        iss_en_s    = 1'b0;
        iss_first_s = 1'b0;
        iss_op_s    = op_q;
        iss_a_s     = {N{1'b0}};
        iss_b_s     = {N{1'b0}};

        if (((state_q == S_ISSUE) && (wi_q != {IW{1'b0}})) || (state_q == S_DRAIN)) begin
            acc_d[ci_q*N +: N] = alu_out_i;
            zacc_d             = zacc_q & alu_flag_zero_i;
            ci_d               = ci_q + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            ci_d = ci_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && (op_i == OP_ERR)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                end else if (start_i) begin
                    state_d     = S_ISSUE;
                    a_d         = a_i;
                    b_d         = b_i;
                    op_d        = op_i;
                    wi_d        = {IW{1'b0}};
                    ci_d        = {IW{1'b0}};
                    zacc_d      = 1'b1;
                    err_d       = 1'b0;
                    iss_en_s    = 1'b1;
                    iss_first_s = 1'b1;
                    iss_op_s    = op_i;
                    iss_a_s     = a_i[N-1:0];
                    iss_b_s     = b_i[N-1:0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (wi_q == LAST) begin
                    state_d = S_DRAIN;
                    wi_d    = {IW{1'b0}};
                end else begin
                    wi_d     = wi_q + {{(IW-1){1'b0}}, 1'b1};
                    iss_en_s = 1'b1;
                    iss_a_s  = a_q[wi_d*N +: N];
                    iss_b_s  = b_q[wi_d*N +: N];
                end
            end
            S_DRAIN: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = acc_d;
                carry_d  = (op_q == OP_XOR) ? 1'b0 : alu_flag_carry_i;
                zero_d   = zacc_d;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (iss_en_s) begin
            alu_en_d   = 1'b1;
            alu_mode_d = word_mode(iss_op_s, iss_first_s);
            alu_a_d    = iss_a_s;
            alu_b_d    = (iss_op_s == OP_INC) ? {N{1'b0}} : iss_b_s;
        end else begin
            alu_en_d   = 1'b0;
            alu_mode_d = 3'd0;
            alu_a_d    = {N{1'b0}};
            alu_b_d    = {N{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            wi_q       <= {IW{1'b0}};
            ci_q       <= {IW{1'b0}};
            a_q        <= {W{1'b0}};
            b_q        <= {W{1'b0}};
            acc_q      <= {W{1'b0}};
            result_q   <= {W{1'b0}};
            op_q       <= 2'd0;
            zacc_q     <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            alu_en_q   <= 1'b0;
            alu_mode_q <= 3'd0;
            alu_a_q    <= {N{1'b0}};
            alu_b_q    <= {N{1'b0}};
        end else begin
            state_q    <= state_d;
            wi_q       <= wi_d;
            ci_q       <= ci_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            op_q       <= op_d;
            zacc_q     <= zacc_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
            done_q     <= done_d;
            alu_en_q   <= alu_en_d;
            alu_mode_q <= alu_mode_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign carry_o      = carry_q;
    assign zero_o       = zero_q;
    assign err_o        = err_q;
    assign alu_enable_o = alu_en_q;
    assign alu_mode_o   = alu_mode_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: a registered 8-bit ALU model plus a wide-integer reference model.
module tb_alu_wide_seq;
    localparam int         N = 8;
    localparam int         WORDS = 4;
    localparam int         W = N * WORDS;
    localparam logic [2:0] M_ADD = 3'd0;
    localparam logic [2:0] M_ADC = 3'd2;
    localparam logic [2:0] M_INC = 3'd3;
    localparam logic [2:0] M_XOR = 3'd6;

    logic           clk = 1'b0;
    logic           reset, start;
    logic [1:0]     op_in;
    logic [W-1:0]   a_in, b_in;
    logic           busy, done, carry, zero, err, alu_enable;
    logic [W-1:0]   result;
    logic [2:0]     alu_mode;
    logic [N-1:0]   alu_a, alu_b, alu_out;
    logic           alu_fz, alu_fc;

    int n_cmp = 0;
    int n_mis = 0;
    logic [W-1:0] exp_res = '0;

    alu_wide_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op_in),
        .a_i(a_in), .b_i(b_in), .busy_o(busy), .done_o(done),
        .result_o(result), .carry_o(carry), .zero_o(zero), .err_o(err),
        .alu_enable_o(alu_enable), .alu_mode_o(alu_mode),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_out_i(alu_out),
        .alu_flag_zero_i(alu_fz), .alu_flag_carry_i(alu_fc)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] alu_f(input logic [2:0] m, input logic [N-1:0] x, y,
                                         input logic c);
        case (m)
            M_ADD:   return {1'b0, x} + {1'b0, y};
            M_ADC:   return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
            M_INC:   return {1'b0, x} + 9'd1;
            M_XOR:   return {1'b0, x ^ y};
            default: return 9'd0;
        endcase
    endfunction

    // Shared ALU: result and flags registered, carry flag persists between uses.
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_out <= alu_f(alu_mode, alu_a, alu_b, alu_fc)[N-1:0];
            alu_fz  <= (alu_f(alu_mode, alu_a, alu_b, alu_fc)[N-1:0] == 8'd0);
            alu_fc  <= alu_f(alu_mode, alu_a, alu_b, alu_fc)[N];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0. Returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W:0]         s;
        logic [3*WORDS-1:0] ms, ems;
        logic [W-1:0]       as_seen, bs_seen;
        int                 cyc, nen, bad;
        bit                 seen_done;
        case (op)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} + 33'd1;
            2'd2:    s = {1'b0, a ^ b};
            default: s = {1'b0, exp_res};
        endcase
        for (int k = 0; k < WORDS; k++)
            ems[3*k +: 3] = (op == 2'd2) ? M_XOR : (k > 0) ? M_ADC : (op == 2'd1) ? M_INC : M_ADD;
        ms = '0; as_seen = '0; bs_seen = '0;
        start = 1'b1; op_in = op; a_in = a; b_in = b;
        @(negedge clk);
        cyc = 1; nen = 0; bad = 0; seen_done = 0;
        while (!seen_done && cyc < 20) begin
            if (alu_enable && nen < WORDS) begin
                ms[3*nen +: 3]      = alu_mode;
                as_seen[N*nen +: N] = alu_a;
                bs_seen[N*nen +: N] = alu_b;
                nen++;
            end else if (alu_enable) begin
                nen++;
            end else if ((alu_mode != 3'd0) || (alu_a != 8'd0) || (alu_b != 8'd0)) begin
                bad++;
            end
            if (busy !== ((op != 2'd3) && (cyc <= WORDS + 1))) bad++;
            start = poke && (cyc == 2);
            if (start) begin
                op_in = 2'd2; a_in = $urandom; b_in = $urandom;
            end
            if (done) seen_done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_cycle", cyc, (op == 2'd3) ? 1 : WORDS + 2);
        chk("err", err, (op == 2'd3));
        if (op != 2'd3) exp_res = s[W-1:0];
        chk("result", result, exp_res);
        chk("carry", carry, (op == 2'd0 || op == 2'd1) ? s[W] : 1'b0);
        chk("zero", zero, (op != 2'd3) && (s[W-1:0] == '0));
        chk("enable_count", nen, (op == 2'd3) ? 0 : WORDS);
        chk("busy_idle_drive", bad, 0);
        if (op != 2'd3) begin
            chk("mode_seq", ms, ems);
            chk("alu_a_seq", as_seen, a);
            chk("alu_b_seq", bs_seen, (op == 2'd1) ? '0 : b);
        end
    endtask

    initial begin
        int bad;
        logic [1:0] rop;
        reset = 1'b1; start = 1'b0; op_in = 2'd0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, err, carry, zero, alu_enable, alu_mode, alu_a, alu_b, result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'd0, 32'h00FFFFFF, 32'h00000001, 0);
        @(negedge clk);
        run_op(2'd0, 32'hFFFFFFFF, 32'h00000001, 0);
        @(negedge clk);
        run_op(2'd1, 32'h123456FF, $urandom, 0);
        @(negedge clk);
        run_op(2'd2, 32'hA5A55A5A, 32'hA5A55A5A, 0);
        run_op(2'd2, 32'hA5A55A5A, 32'h00000000, 0);
        @(negedge clk);
        run_op(2'd3, $urandom, $urandom, 0);
        @(negedge clk);
        chk("hold_after_err", result, exp_res);
        run_op(2'd0, 32'h89ABCDEF, 32'h76543211, 1);

        // Reset in cycle 3 of an ADD discards the sequence.
        @(negedge clk);
        start = 1'b1; op_in = 2'd0; a_in = 32'h11111111; b_in = 32'h22222222;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outs", {busy, done, err, carry, zero, alu_enable, alu_mode, alu_a, alu_b, result}, 64'd0);
        reset = 1'b0;
        exp_res = '0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("no_done_after_reset", bad, 0);
        run_op(2'd0, 32'hDEADBEEF, 32'h21524111, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       run_op(rop, 32'hFFFFFFFF, $urandom, 0);
                1:       run_op(rop, $urandom, 32'hFFFFFFFF - $urandom_range(0, 2), 0);
                default: run_op(rop, $urandom, $urandom, $urandom_range(0, 1) == 1);
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
